// File: rtl/mmio_pkg.sv
// Shared CPU data-bus peripheral definitions: address map, UART transmitter
// FSM encoding and status-word layout.
package mmio_pkg;

  localparam logic [31:0] UART_STATUS_ADDR = 32'd252;
  localparam logic [31:0] UART_DATA_ADDR   = 32'd253;
  localparam logic [31:0] GPIO_ADDR_0      = 32'd254;
  localparam logic [31:0] GPIO_ADDR_1      = 32'd255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_OVERRUN = 3;

  function automatic logic [63:0] status_word(input logic overrun, input logic empty,
                                              input logic full, input logic busy);
    logic [63:0] w;
    w               = 64'd0;
    w[STAT_OVERRUN] = overrun;
    w[STAT_EMPTY]   = empty;
    w[STAT_FULL]    = full;
    w[STAT_BUSY]    = busy;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular byte queue feeding the UART transmitter; a push while full is
// accepted only when a pop happens on the same edge.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] push_data,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == CW'(0));
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointers and occupancy; both pointers wrap modulo DEPTH.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? AW'(0) : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? AW'(0) : rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. Define MMIO_UART_TX_FIFO_EN for a
// FIFO_DEPTH-byte queue; otherwise a single holding register is used.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] DATA_ADDRESS   = UART_DATA_ADDR,
  parameter logic [31:0] STATUS_ADDRESS = UART_STATUS_ADDR,
  parameter int          CLKS_PER_BIT   = 16,
  parameter int          FIFO_DEPTH     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_address,
  inout  wire  [63:0] mem_data,
  input  logic        mem_write_en,
  input  logic        mem_read,
  output logic        tx,
  output logic        tx_busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  uart_tx_state_e state, state_next;
  logic [CW-1:0]  baud_cnt, baud_next;
  logic [2:0]     bit_idx, bit_next;
  logic [7:0]     shreg, shreg_next;
  logic [7:0]     pop_data;
  logic           tx_next, pop, baud_done;
  logic           write_hit, read_hit, overrun, overrun_set;
  logic           fifo_full, fifo_empty;
  logic           unused_bus_bits;

  assign write_hit   = mem_write_en && (mem_address == DATA_ADDRESS);
  assign read_hit    = mem_read && (mem_address == STATUS_ADDRESS);
  assign baud_done   = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign tx_busy     = (state != IDLE);
  assign overrun_set = write_hit && fifo_full && !pop;
  assign mem_data    = read_hit ? status_word(overrun, fifo_empty, fifo_full, tx_busy)
                                : {64{1'bz}};

`ifdef MMIO_UART_TX_FIFO_EN
  assign unused_bus_bits = ^mem_data[63:8];

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (write_hit),
    .pop       (pop),
    .push_data (mem_data[7:0]),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
`else
  logic       hold_valid;
  logic [7:0] hold_data;

  assign unused_bus_bits = ^{mem_data[63:8], FIFO_DEPTH[0]};
  assign fifo_empty      = ~hold_valid;
  assign fifo_full       = hold_valid;
  assign pop_data        = hold_data;

  // Depth-1 queue: a write while occupied lands only if the FSM pops this edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_valid <= 1'b0;
      hold_data  <= 8'd0;
    end else if (write_hit && (!hold_valid || pop)) begin
      hold_valid <= 1'b1;
      hold_data  <= mem_data[7:0];
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  // Sticky overrun: a dropped write outranks a same-edge status-read clear.
  always_ff @(posedge clock) begin
    if (!reset)           overrun <= 1'b0;
    else if (overrun_set) overrun <= 1'b1;
    else if (read_hit)    overrun <= 1'b0;
  end

  // Next-state logic; tx is computed from the next state so it stays registered.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt + CW'(1);
    bit_next   = bit_idx;
    shreg_next = shreg;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        baud_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shreg_next = pop_data;
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (baud_done) begin
          state_next = DATA;
          baud_next  = '0;
          bit_next   = 3'd0;
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end else begin
          state_next = DATA;
        end
      end
      STOP: begin
        if (baud_done) begin
          state_next = IDLE;
          baud_next  = '0;
        end else begin
          state_next = STOP;
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = '0;
      end
    endcase
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[bit_next];
      default: tx_next = 1'b1;
    endcase
  end

  // Transmitter state register; reset abandons any frame in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'd0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shreg    <= shreg_next;
      tx       <= tx_next;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised scoreboard bench for mmio_uart_tx: a queue-and-frame-timer model
// predicts frames and status words; a negedge monitor decodes tx and compares.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
`ifdef MMIO_UART_TX_FIFO_EN
  localparam int QDEPTH = 4;
`else
  localparam int QDEPTH = 1;
`endif
  localparam logic [31:0] A_STATUS = 32'd252;
  localparam logic [31:0] A_DATA   = 32'd253;
  localparam logic [31:0] A_OTHER  = 32'd254;

  typedef struct {
    logic [7:0] b;
    int         edge_no;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] mem_address;
  logic        mem_write_en;
  logic        mem_read;
  logic        tx;
  logic        tx_busy;
  logic [63:0] drv;
  logic        drv_en;
  wire  [63:0] mem_data;

  assign mem_data = drv_en ? drv : {64{1'bz}};

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mmio_uart_tx #(
    .DATA_ADDRESS   (A_DATA),
    .STATUS_ADDRESS (A_STATUS),
    .CLKS_PER_BIT   (CPB),
    .FIFO_DEPTH     (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_write_en (mem_write_en),
    .mem_read     (mem_read),
    .tx           (tx),
    .tx_busy      (tx_busy)
  );

  // Reference model: pending bytes, remaining frame clocks, sticky overrun.
  logic [7:0]  m_q[$];
  int          m_busy = 0;
  bit          m_ovr  = 1'b0;
  int          cyc    = 0;
  exp_t        sb_q[$];
  logic [63:0] st_q[$];

  function automatic logic [63:0] m_status();
    return {60'd0, m_ovr, (m_q.size() == 0), (m_q.size() == QDEPTH), (m_busy > 0)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit   pop, whit, rhit, set_ovr;
    exp_t e;
    cyc++;
    if (!reset) begin
      m_q.delete();
      m_busy = 0;
      m_ovr  = 1'b0;
      return;
    end
    pop     = (m_busy == 0) && (m_q.size() > 0);
    whit    = mem_write_en && (mem_address == A_DATA);
    rhit    = mem_read && (mem_address == A_STATUS);
    set_ovr = 1'b0;
    if (pop) begin
      e.b       = m_q.pop_front();
      e.edge_no = cyc;
      sb_q.push_back(e);
      m_busy = FRAME;
    end else if (m_busy > 0) begin
      m_busy--;
    end
    if (whit) begin
      if (m_q.size() < QDEPTH) m_q.push_back(drv[7:0]);
      else set_ovr = 1'b1;
    end
    if (set_ovr) m_ovr = 1'b1;
    else if (rhit) m_ovr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic bus_idle();
    mem_address  = 32'd0;
    mem_write_en = 1'b0;
    mem_read     = 1'b0;
    drv_en       = 1'b0;
    drv          = 64'd0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [7:0] b);
    mem_address  = addr;
    mem_write_en = 1'b1;
    mem_read     = 1'b0;
    drv          = {$urandom, $urandom};
    drv[7:0]     = b;
    drv_en       = 1'b1;
    tick();
    bus_idle();
  endtask

  task automatic status_read();
    mem_address  = A_STATUS;
    mem_read     = 1'b1;
    mem_write_en = 1'b0;
    drv_en       = 1'b0;
    st_q.push_back(m_status());
    tick();
    bus_idle();
  endtask

  // The bench drives a pattern; any DUT drive would corrupt it.
  task automatic hiz_check(input logic [31:0] addr);
    logic [63:0] pat;
    pat          = {$urandom, $urandom};
    pat[3:0]     = 4'h0;
    mem_address  = addr;
    mem_read     = 1'b1;
    mem_write_en = 1'b0;
    drv          = pat;
    drv_en       = 1'b1;
    #1;
    check("bus_hiz", mem_data, pat);
    tick();
    bus_idle();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_busy > 0 || m_q.size() > 0) && n < 3000) begin
      tick();
      n++;
    end
    check("idle_timeout", (n >= 3000), 1'b0);
    tick();
    tick();
  endtask

  // Monitor: decodes frames from tx, checks busy/idle line, consumes status words.
  initial begin
    bit          rx_on;
    int          rx_t, k;
    logic [7:0]  rx_b;
    exp_t        rx_e;
    logic [63:0] st_e;
    rx_on = 1'b0;
    rx_t  = 0;
    rx_b  = 8'd0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        rx_on = 1'b0;
        continue;
      end
      check("tx_busy", tx_busy, (m_busy > 0));
      if (mem_read && mem_address == A_STATUS) begin
        if (st_q.size() == 0) begin
          check("status_unexpected", 1'b1, 1'b0);
        end else begin
          st_e = st_q.pop_front();
          check("status", mem_data, st_e);
        end
      end
      if (!rx_on) begin
        if (m_busy == 0) check("tx_idle_high", tx, 1'b1);
        if (tx == 1'b0) begin
          rx_on = 1'b1;
          rx_t  = 0;
          if (sb_q.size() == 0) begin
            check("frame_unexpected", 1'b1, 1'b0);
            rx_e.b       = 8'd0;
            rx_e.edge_no = cyc;
          end else begin
            rx_e = sb_q.pop_front();
            check("start_cycle", cyc, rx_e.edge_no);
          end
        end
      end
      if (rx_on) begin
        if (rx_t % CPB == CPB / 2) begin
          k = rx_t / CPB;
          if (k == 0) check("start_bit", tx, 1'b0);
          else if (k <= 8) rx_b[k-1] = tx;
          else begin
            check("stop_bit", tx, 1'b1);
            check("frame_byte", rx_b, rx_e.b);
          end
        end
        rx_t++;
        if (rx_t == FRAME) rx_on = 1'b0;
      end
    end
  end

  initial begin
    int r, n;
    bus_idle();
    reset = 1'b0;
    repeat (3) tick();
    check("reset_tx", tx, 1'b1);
    check("reset_busy", tx_busy, 1'b0);
    reset = 1'b1;
    status_read();
    hiz_check(A_DATA);
    hiz_check(A_OTHER);

    // Single byte, full frame timing.
    bus_write(A_DATA, 8'hA5);
    wait_idle();

    // Consecutive writes, then back-to-back frames.
    for (int i = 1; i <= 5; i++) bus_write(A_DATA, 8'(i));
    status_read();
    status_read();
    wait_idle();

    // Overflow: fill while transmitting, then write 8'hFF with no pop.
    n = 0;
    while (!(m_q.size() == QDEPTH && m_busy > 0) && n < 10) begin
      bus_write(A_DATA, 8'($urandom_range(0, 254)));
      n++;
    end
    bus_write(A_DATA, 8'hFF);
    status_read();
    status_read();
    wait_idle();

    // Reset during data bit 3 with bytes still queued.
    bus_write(A_DATA, 8'h3C);
    bus_write(A_DATA, 8'hC3);
    bus_write(A_DATA, 8'h5A);
    n = 0;
    while (m_busy != FRAME - 4 * CPB - 1 && n < 100) begin
      tick();
      n++;
    end
    reset = 1'b0;
    tick();
    check("midframe_tx", tx, 1'b1);
    check("midframe_busy", tx_busy, 1'b0);
    reset = 1'b1;
    status_read();
    repeat (2 * FRAME) tick();

    // Misaddressed accesses do nothing.
    bus_write(A_OTHER, 8'h77);
    bus_write(A_STATUS, 8'h66);
    status_read();
    hiz_check(A_DATA);
    repeat (FRAME) tick();

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 12)      bus_write(A_DATA, 8'($urandom));
      else if (r < 16) bus_write(A_OTHER, 8'($urandom));
      else if (r < 20) bus_write(A_STATUS, 8'($urandom));
      else if (r < 30) status_read();
      else if (r < 34) hiz_check(($urandom_range(0, 1) == 0) ? A_DATA : A_OTHER);
      else             tick();
    end
    wait_idle();
    check("scoreboard_drained", sb_q.size(), 0);
    check("status_drained", st_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
